// File: rtl/divider_seq_if.sv
// ---------------------------------------------------------------------------
// divider_seq_if : start/operand/result bundle for the sequential divider
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divider_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             ld_q;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, ld_q, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, ld_q, quotient, remainder, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/divider_seq.sv
// ---------------------------------------------------------------------------
// divider_seq : radix-2 restoring divider, WIDTH cycles per quotient.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  divider_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             busy_q;
  logic             done_q;
  logic             ld_q_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;
`ifdef DIVIDER_SIGNED_EN
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] quo_res;
  logic [WIDTH-1:0] rem_res;
  logic [WIDTH-1:0] op_dvd;
  logic [WIDTH-1:0] op_dvs;

  // A restore only happens when shifted < divisor, so its MSB is then zero
  // and the kept partial remainder always fits in WIDTH bits.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef DIVIDER_SIGNED_EN
    quo_res = neg_quo_q ? -dvd_d : dvd_d;
    rem_res = neg_rem_q ? -rem_d : rem_d;
    op_dvd  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    op_dvs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    quo_res = dvd_d;
    rem_res = rem_d;
    op_dvd  = bus.dividend;
    op_dvs  = bus.divisor;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_q_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ld_q_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            if (bus.divisor == '0) begin
              state_q   <= S_DONE;
              quo_out_q <= '1;
              rem_out_q <= bus.dividend;
              dbz_q     <= 1'b1;
              done_q    <= 1'b1;
              ld_q_q    <= 1'b1;
            end else begin
              state_q <= S_CALC;
              dbz_q   <= 1'b0;
              rem_q   <= '0;
              dvd_q   <= op_dvd;
              dvs_q   <= op_dvs;
`ifdef DIVIDER_SIGNED_EN
              neg_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              neg_rem_q <= bus.dividend[WIDTH-1];
`endif
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          // Last quotient bit: publish the fixed-up result on DONE entry
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q   <= S_DONE;
            quo_out_q <= quo_res;
            rem_out_q <= rem_res;
            done_q    <= 1'b1;
            ld_q_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ld_q        = ld_q_q;
  assign bus.quotient    = quo_out_q;
  assign bus.remainder   = rem_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result bit width; the quotient output feeds the downstream 16-bit quotient register.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled only on posedge clk.
REQ-004 start  input  1  request to begin a division; accepted only in IDLE.
REQ-005 dividend  input  WIDTH  numerator; sampled on the accepting edge only.
REQ-006 divisor  input  WIDTH  denominator; sampled on the accepting edge only.
REQ-007 busy  output  1  high from the accepting edge until return to IDLE.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 ld_q  output  1  one-cycle load strobe to the quotient register; identical timing to done.
REQ-010 quotient  output  WIDTH  result quotient.
REQ-011 remainder  output  WIDTH  result remainder.
REQ-012 div_by_zero  output  1  high with done when divisor was 0; held until the next accepted start.

Function
REQ-013 FSM states IDLE, CALC, DONE; IDLE->CALC on start with divisor!=0; IDLE->DONE on start with divisor==0; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 Algorithm: radix-2 restoring, one quotient bit per CALC cycle, MSB first; partial remainder WIDTH+1 bits wide to hold the trial subtraction sign.
REQ-015 Latency: start accepted at edge k -> done/ld_q high in the cycle after edge k+WIDTH (WIDTH+1 cycles after acceptance).
REQ-016 done and ld_q high only in DONE, exactly one cycle per accepted start.
REQ-017 quotient/remainder update only on entry to DONE and hold until the next DONE entry; internal iteration values never appear on the outputs.
REQ-018 start while busy (CALC or DONE): ignored, no effect on the operation or operands in progress.
REQ-019 Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1, done after 1 cycle (cycle after edge k).
REQ-020 Back-to-back: start high during the DONE cycle is ignored; the next start is accepted in IDLE at the earliest one cycle later.
REQ-021 Unsigned mode: quotient = floor(dividend/divisor), remainder = dividend - quotient*divisor < divisor.

Reset
REQ-022 rst low at posedge clk: state=IDLE, iteration counter=0, busy=0, done=0, ld_q=0, div_by_zero=0, quotient=0, remainder=0.
REQ-023 Reset mid-operation (CALC or DONE): abort, no done/ld_q pulse, outputs zeroed per REQ-022.
REQ-024 start asserted in the same cycle as reset: ignored.

Configuration
REQ-025 Macro DIVIDER_SIGNED_EN: when defined, operands are two's complement and the quotient truncates toward zero.
REQ-026 With DIVIDER_SIGNED_EN: the remainder takes the dividend's sign, |remainder| < |divisor|, magnitude division is followed by sign fix-up inside the same latency as REQ-015, and most-negative/-1 yields quotient = 0x8000 (WIDTH=16) with remainder 0.
REQ-027 Without DIVIDER_SIGNED_EN: unsigned only per REQ-021; no sign logic is synthesized.
REQ-028 Divide-by-zero behaviour per REQ-019 applies in both modes (remainder = raw dividend bits).

Verification
REQ-029 Unsigned: dividend=1000, divisor=7 -> quotient=142, remainder=6, done and ld_q high for exactly 1 cycle, 17 cycles after acceptance.
REQ-030 Unsigned: 0xFFFF / 0x0001 -> quotient=0xFFFF, remainder=0; 0x0003 / 0x0010 -> quotient=0, remainder=3.
REQ-031 Zero divisor: 5 / 0 -> quotient=0xFFFF, remainder=5, div_by_zero=1, done in the cycle after acceptance.
REQ-032 start pulsed with 20/3 at cycle 5 of 100/9 in progress -> result 11 r 1 only, a single done pulse, the second request dropped.
REQ-033 rst low at CALC cycle 8 -> busy=0, quotient=0, remainder=0, no done/ld_q until the next start.
REQ-034 DIVIDER_SIGNED_EN: -7 / 2 -> quotient=0xFFFD (-3), remainder=0xFFFF (-1); 0x8000 / 0xFFFF -> quotient=0x8000, remainder=0.
